// File: rtl/comp_strg_master.sv
// Command initiator for the computation-storage block: one request in flight,
// drives the storage command bus and tri-state DQ, returns one response per request.
module comp_strg_master #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_addA,
  input  logic [ADDR_W-1:0] req_addB,
  input  logic [ADDR_W-1:0] req_addC,
  input  logic [DATA_W-1:0] req_wdata,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_err,
  output logic [DATA_W-1:0] rsp_data,

  output logic              en,
  output logic [1:0]        cmd,
  output logic [ADDR_W-1:0] addA,
  output logic [ADDR_W-1:0] addB,
  output logic [ADDR_W-1:0] addC,
  inout  wire  [DATA_W-1:0] DQ,
  input  logic              valid_out
);

  localparam logic [1:0] CMD_READ  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_ADD   = 2'd2;
  localparam logic [1:0] CMD_SUB   = 2'd3;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } state_t;

  state_t            state;
  logic [7:0]        wait_cnt;
  logic              dq_oe;
  logic [DATA_W-1:0] dq_out;
  logic              req_illegal;

  // ADD/SUB with identical operand addresses is rejected without touching storage.
  assign req_illegal = ((req_cmd == CMD_ADD) || (req_cmd == CMD_SUB)) &&
                       (req_addA == req_addB);

  assign req_ready = (state == IDLE) && !rst;

  // NOTE: the bus is released by driving all-Z; only the flopped enable opens the driver.
  assign DQ = dq_oe ? dq_out : {DATA_W{1'bz}};

  // NOTE: every register here is assigned with <= so all flops update from the
  // same pre-edge values; mixing in = would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      en        <= 1'b0;
      cmd       <= '0;
      addA      <= '0;
      addB      <= '0;
      addC      <= '0;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= ERR_OK;
      rsp_data  <= '0;
    end else begin
      en    <= 1'b0;
      dq_oe <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_illegal) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= ERR_ILLEGAL;
              rsp_data  <= '0;
            end else begin
              state  <= ISSUE;
              en     <= 1'b1;
              cmd    <= req_cmd;
              addA   <= req_addA;
              addB   <= req_addB;
              addC   <= req_addC;
              dq_out <= req_wdata;
              dq_oe  <= (req_cmd == CMD_WRITE);
            end
          end
        end

        ISSUE: begin
          if (cmd == CMD_READ) begin
            state    <= WAIT_RD;
            wait_cnt <= 8'd1;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_OK;
            rsp_data  <= '0;
          end
        end

        WAIT_RD: begin
          // Data arriving on the final counted cycle still wins over the timeout.
          if (valid_out) begin
            state     <= RESP;
            wait_cnt  <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_OK;
            rsp_data  <= DQ;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            state     <= RESP;
            wait_cnt  <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_TIMEOUT;
            rsp_data  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_strg_master.sv
// Directed bench for comp_strg_master with a small storage model that answers
// READs one cycle after the en pulse and parks a known value on idle DQ.
module tb_comp_strg_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_cmd;
  logic [3:0] req_addA, req_addB, req_addC;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_err;
  logic [7:0] rsp_data;
  logic       en;
  logic [1:0] cmd;
  logic [3:0] addA, addB, addC;
  wire  [7:0] DQ;
  logic       valid_out;

  int n_cmp = 0;
  int n_err = 0;

  // Storage model controls
  logic       mute   = 1'b0;   // suppress READ answers
  logic       park   = 1'b1;   // drive 0x3C on DQ when nobody else should
  logic       man_vo = 1'b0;   // manual valid_out
  logic [7:0] man_val = 8'h00;
  logic       rd_pend = 1'b0;
  logic [7:0] rd_val  = 8'h00;
  logic [7:0] mem [16];
  logic       tb_oe;
  logic [7:0] tb_val;

  always #5 clk = ~clk;

  comp_strg_master #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_addA  (req_addA),
    .req_addB  (req_addB),
    .req_addC  (req_addC),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .en        (en),
    .cmd       (cmd),
    .addA      (addA),
    .addB      (addB),
    .addC      (addC),
    .DQ        (DQ),
    .valid_out (valid_out)
  );

  always @(posedge clk) begin
    if (en && cmd == 2'd1) mem[addA] <= DQ;
    rd_pend <= en && (cmd == 2'd0) && !mute;
    rd_val  <= mem[addA];
  end

  assign valid_out = rd_pend | man_vo;
  assign tb_oe     = rd_pend | man_vo | park;
  assign tb_val    = man_vo ? man_val : (rd_pend ? rd_val : 8'h3C);
  assign DQ        = tb_oe ? tb_val : 8'hzz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic req(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] d, input logic [7:0] wd);
    req_valid = 1'b1;
    req_cmd   = c;
    req_addA  = a;
    req_addB  = b;
    req_addC  = d;
    req_wdata = wd;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_cmd = 2'd0;
    req_addA = '0; req_addB = '0; req_addC = '0; req_wdata = '0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (2) nxt();
    check("rst_en", en, 0);
    check("rst_cmd", cmd, 0);
    check("rst_addA", addA, 0);
    check("rst_addB", addB, 0);
    check("rst_addC", addC, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_dq_z", DQ, 8'h3C);
    rst = 1'b0;
    #1 check("post_rst_ready", req_ready, 1);

    // WRITE addA=3, wdata=0xA5
    nxt();
    check("wr_dq_before", DQ, 8'h3C);
    req(2'd1, 4'd3, 4'd0, 4'd0, 8'hA5);
    check("wr_ready", req_ready, 1);
    park = 1'b0;
    nxt();
    req_valid = 1'b0;
    check("wr_en", en, 1);
    check("wr_cmd", cmd, 1);
    check("wr_addA", addA, 3);
    check("wr_dq", DQ, 8'hA5);
    check("wr_rsp_early", rsp_valid, 0);
    @(posedge clk); #1 park = 1'b1;
    nxt();
    check("wr_en_drop", en, 0);
    check("wr_dq_after", DQ, 8'h3C);
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_rsp_data", rsp_data, 0);
    nxt();
    check("wr_rsp_gone", rsp_valid, 0);
    check("wr_idle_ready", req_ready, 1);
    check("wr_cmd_hold", cmd, 1);
    check("wr_addA_hold", addA, 3);

    // READ addA=3, storage answers 0xA5 one cycle after en
    req(2'd0, 4'd3, 4'd0, 4'd0, 8'h00);
    nxt();
    req_valid = 1'b0;
    check("rd_en", en, 1);
    check("rd_cmd", cmd, 0);
    check("rd_addA", addA, 3);
    nxt();
    check("rd_en_drop", en, 0);
    check("rd_rsp_early", rsp_valid, 0);
    nxt();
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_err", rsp_err, 0);
    check("rd_rsp_data", rsp_data, 8'hA5);
    nxt();
    check("rd_rsp_gone", rsp_valid, 0);

    // Illegal ADD addA==addB
    req(2'd2, 4'd2, 4'd2, 4'd5, 8'h00);
    nxt();
    req_valid = 1'b0;
    check("ill_no_en", en, 0);
    check("ill_rsp_valid", rsp_valid, 1);
    check("ill_rsp_err", rsp_err, 1);
    check("ill_rsp_data", rsp_data, 0);
    check("ill_cmd_hold", cmd, 0);
    check("ill_addC_hold", addC, 0);
    nxt();
    check("ill_rsp_gone", rsp_valid, 0);
    check("ill_no_en2", en, 0);

    // SUB addA=1 addB=4 addC=6
    req(2'd3, 4'd1, 4'd4, 4'd6, 8'h00);
    nxt();
    req_valid = 1'b0;
    check("sub_en", en, 1);
    check("sub_cmd", cmd, 3);
    check("sub_addA", addA, 1);
    check("sub_addB", addB, 4);
    check("sub_addC", addC, 6);
    nxt();
    check("sub_rsp_valid", rsp_valid, 1);
    check("sub_rsp_err", rsp_err, 0);
    nxt();

    // READ with no valid_out: timeout response in cycle k+10
    mute = 1'b1;
    req(2'd0, 4'd7, 4'd0, 4'd0, 8'h00);
    nxt();
    req_valid = 1'b0;
    check("to_wait_1", rsp_valid, 0);
    for (int i = 2; i <= 9; i++) begin
      nxt();
      check($sformatf("to_wait_%0d", i), rsp_valid, 0);
    end
    nxt();
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 2);
    check("to_rsp_data", rsp_data, 0);
    nxt();

    // valid_out on the last counted cycle still succeeds
    req(2'd0, 4'd3, 4'd0, 4'd0, 8'h00);
    nxt();
    req_valid = 1'b0;
    for (int i = 2; i <= 8; i++) nxt();
    nxt();
    check("edge_wait", rsp_valid, 0);
    man_val = 8'h77;
    man_vo  = 1'b1;
    nxt();
    man_vo = 1'b0;
    check("edge_rsp_valid", rsp_valid, 1);
    check("edge_rsp_err", rsp_err, 0);
    check("edge_rsp_data", rsp_data, 8'h77);
    mute = 1'b0;
    nxt();

    // Backpressure: response held while rsp_ready=0
    rsp_ready = 1'b0;
    req(2'd0, 4'd3, 4'd0, 4'd0, 8'h00);
    nxt();
    req_valid = 1'b0;
    nxt();
    nxt();
    req(2'd2, 4'd1, 4'd2, 4'd8, 8'h00);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_valid_%0d", i), rsp_valid, 1);
      check($sformatf("hold_data_%0d", i), rsp_data, 8'hA5);
      check($sformatf("hold_err_%0d", i), rsp_err, 0);
      check($sformatf("hold_ready_%0d", i), req_ready, 0);
      check($sformatf("hold_no_en_%0d", i), en, 0);
      nxt();
    end
    check("hold_last", rsp_valid, 1);
    rsp_ready = 1'b1;
    nxt();
    check("hold_released", rsp_valid, 0);
    check("hold_req_ready", req_ready, 1);
    nxt();
    req_valid = 1'b0;
    check("second_en", en, 1);
    check("second_cmd", cmd, 2);
    check("second_addA", addA, 1);
    check("second_addC", addC, 8);
    nxt();
    check("second_rsp", rsp_valid, 1);
    check("second_err", rsp_err, 0);
    nxt();

    // Reset during a WRITE issue
    park = 1'b0;
    req(2'd1, 4'd5, 4'd0, 4'd0, 8'hC3);
    nxt();
    req_valid = 1'b0;
    check("rstw_en", en, 1);
    check("rstw_dq", DQ, 8'hC3);
    rst = 1'b1;
    @(posedge clk); #1 park = 1'b1;
    nxt();
    check("rstw_en_drop", en, 0);
    check("rstw_dq_z", DQ, 8'h3C);
    check("rstw_no_rsp", rsp_valid, 0);
    check("rstw_ready_low", req_ready, 0);
    check("rstw_cmd", cmd, 0);
    rst = 1'b0;
    #1 check("rstw_ready_back", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      nxt();
      check($sformatf("rstw_quiet_%0d", i), rsp_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
